// File: rtl/ecu_pkg.sv
// Shared ECU definitions: fetch FSM states and fetch-unit defaults.
package ecu_pkg;

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_D  = 2'd1,
        EXEC     = 2'd2
    } ifu_state_e;

    localparam int unsigned RESET_PC_DEFAULT = 0;
    localparam int          CNT_W            = 2;

endpackage

// File: rtl/ifu_pc.sv
// Program counter for the fetch unit: increments per fetched byte, loads on redirect, wraps mod 2^AW.
module ifu_pc
    import ecu_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= AW'(RESET_PC);
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: fetches opcode plus len operand bytes, then holds the bundle in EXEC until done.
module ifu
    import ecu_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    input  logic [1:0]    len,
    input  logic          done,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_target,
    output logic [7:0]    insn,
    output logic [7:0]    d1,
    output logic [7:0]    d2,
    output logic [7:0]    d3,
    output logic [2:0]    is,
    output logic          exec,
    output logic [AW-1:0] insn_pc
);

    ifu_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [AW-1:0]    pc;
    logic             byte_done;

    assign cnt_inc   = cnt + 1'b1;
    assign byte_done = mem_req && mem_ack;
    assign mem_addr  = pc;
    assign exec      = (state == EXEC);

    ifu_pc #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (byte_done),
        .load   (exec && pc_load),
        .target (pc_target),
        .pc     (pc)
    );

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        case (state)
            FETCH_OP: begin
                mem_req = 1'b1;
                if (mem_ack) state_nx = FETCH_D;
            end
            FETCH_D: begin
                if (len == '0) begin
                    state_nx = EXEC;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack && cnt_inc == len) state_nx = EXEC;
                end
            end
            EXEC: begin
                if (done) state_nx = FETCH_OP;
            end
            default: state_nx = FETCH_OP;
        endcase
        // Requests are abandoned for as long as reset is held.
        if (!rst) mem_req = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH_OP;
            cnt     <= '0;
            insn    <= '0;
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
            is      <= '0;
            insn_pc <= '0;
        end else begin
            state <= state_nx;
            case (state)
                FETCH_OP: begin
                    if (mem_ack) begin
                        insn    <= mem_rdata;
                        d1      <= '0;
                        d2      <= '0;
                        d3      <= '0;
                        insn_pc <= pc;
                        cnt     <= '0;
                    end
                end
                FETCH_D: begin
                    if (len != '0 && mem_ack) begin
                        case (cnt)
                            2'd0:    d1 <= mem_rdata;
                            2'd1:    d2 <= mem_rdata;
                            default: d3 <= mem_rdata;
                        endcase
                        cnt <= cnt_inc;
                    end
                end
                EXEC: begin
                    if (done) begin
                        is <= '0;
                    end else if (is != 3'd7) begin
                        is <= is + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: byte memory model with programmable wait states, scenario tasks in sequence.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [1:0]  len;
    logic        done;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [7:0]  insn, d1, d2, d3;
    logic [2:0]  is;
    logic        exec;
    logic [15:0] insn_pc;

    logic [7:0]  mem [0:65535];
    int          wait_n;
    int          wcnt;
    int          ack_count;
    logic        rand_ack_en;
    logic        rand_ack;

    int vecs;
    int errs;

    ifu #(.AW(16), .RESET_PC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .len       (len),
        .done      (done),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .insn      (insn),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .is        (is),
        .exec      (exec),
        .insn_pc   (insn_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always_comb begin
        if (rand_ack_en) mem_ack = rand_ack;
        else             mem_ack = mem_req && (wcnt == wait_n);
    end

    always_ff @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (mem_req && mem_ack)  ack_count <= ack_count + 1;
    end

    // Steps negedges until exec rises; returns the step count (60 means it never rose).
    task automatic run_to_exec(output int n);
        n = 0;
        while (!exec && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Raises done (optionally with a redirect) for one cycle; returns at the first FETCH_OP negedge.
    task automatic finish_insn(input logic load, input logic [15:0] target);
        done      = 1'b1;
        pc_load   = load;
        pc_target = target;
        @(negedge clk);
        done    = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_ack = 1'($urandom_range(0, 1));
            #1;
            vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
            vecs++; if (exec !== 1'b0) begin errs++; $display("FAIL rst_exec got %b want 0", exec); end
            vecs++; if ({insn, d1, d2, d3} !== 32'h0) begin errs++; $display("FAIL rst_bundle got %h want 0", {insn, d1, d2, d3}); end
            vecs++; if ({is, insn_pc, mem_addr} !== 35'h0) begin errs++; $display("FAIL rst_is_pc got %h/%h/%h want 0", is, insn_pc, mem_addr); end
        end
        @(negedge clk);
        rand_ack_en = 1'b0;
        wait_n      = 0;
        len         = 2'd3;
        rst         = 1'b1;
        #1;
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rel_mem_req got %b want 1", mem_req); end
        vecs++; if (mem_addr !== 16'h0000) begin errs++; $display("FAIL rel_mem_addr got %h want 0000", mem_addr); end
    endtask

    task automatic test_three_operands;
        int n;
        run_to_exec(n);
        vecs++; if (n !== 4) begin errs++; $display("FAIL op3_latency got %0d want 4", n); end
        vecs++; if (insn !== 8'd13) begin errs++; $display("FAIL op3_insn got %0d want 13", insn); end
        vecs++; if ({d1, d2, d3} !== {8'd100, 8'd50, 8'd64}) begin errs++; $display("FAIL op3_ops got %0d %0d %0d want 100 50 64", d1, d2, d3); end
        vecs++; if (insn_pc !== 16'h0000) begin errs++; $display("FAIL op3_insn_pc got %h want 0000", insn_pc); end
        for (int i = 0; i < 10; i++) begin
            vecs++;
            if (is !== 3'((i > 7) ? 7 : i)) begin errs++; $display("FAIL op3_is[%0d] got %0d want %0d", i, is, (i > 7) ? 7 : i); end
            if (i < 9) @(negedge clk);
        end
        finish_insn(1'b0, 16'h0000);
        vecs++; if ({exec, mem_req} !== 2'b01) begin errs++; $display("FAIL op3_next_req got exec=%b req=%b want 0/1", exec, mem_req); end
        vecs++; if (mem_addr !== 16'h0004) begin errs++; $display("FAIL op3_next_addr got %h want 0004", mem_addr); end
        vecs++; if (is !== 3'd0) begin errs++; $display("FAIL op3_is_clear got %0d want 0", is); end
    endtask

    task automatic test_zero_operands;
        int n;
        int acks0;
        len   = 2'd0;
        acks0 = ack_count;
        run_to_exec(n);
        vecs++; if (n !== 2) begin errs++; $display("FAIL op0_latency got %0d want 2", n); end
        vecs++; if (insn !== 8'h18) begin errs++; $display("FAIL op0_insn got %h want 18", insn); end
        vecs++; if ({d1, d2, d3} !== 24'h0) begin errs++; $display("FAIL op0_ops_clear got %h want 000000", {d1, d2, d3}); end
        vecs++; if (insn_pc !== 16'h0004) begin errs++; $display("FAIL op0_insn_pc got %h want 0004", insn_pc); end
        vecs++; if (ack_count - acks0 !== 1) begin errs++; $display("FAIL op0_requests got %0d want 1", ack_count - acks0); end
        vecs++; if (is !== 3'd0) begin errs++; $display("FAIL op0_is got %0d want 0", is); end
        finish_insn(1'b0, 16'h0000);
        vecs++; if ({exec, mem_req, mem_addr} !== {2'b01, 16'h0005}) begin errs++; $display("FAIL op0_one_cycle_exec got exec=%b req=%b addr=%h want 0/1/0005", exec, mem_req, mem_addr); end
    endtask

    task automatic test_wait_states;
        len    = 2'd1;
        wait_n = 3;
        for (int c = 0; c < 8; c++) begin
            vecs++;
            if ({exec, mem_req, mem_addr} !== {2'b01, (c < 4) ? 16'h0005 : 16'h0006}) begin
                errs++;
                $display("FAIL wait_cycle[%0d] got exec=%b req=%b addr=%h want 0/1/%h", c, exec, mem_req, mem_addr, (c < 4) ? 16'h0005 : 16'h0006);
            end
            @(negedge clk);
        end
        vecs++; if (exec !== 1'b1) begin errs++; $display("FAIL wait_exec_cycle8 got %b want 1", exec); end
        vecs++; if ({insn, d1, insn_pc} !== {8'h21, 8'h5A, 16'h0005}) begin errs++; $display("FAIL wait_bundle got %h %h %h want 21 5a 0005", insn, d1, insn_pc); end
        wait_n = 0;
        finish_insn(1'b0, 16'h0000);
        vecs++; if (mem_addr !== 16'h0007) begin errs++; $display("FAIL wait_next_addr got %h want 0007", mem_addr); end
    endtask

    task automatic test_redirect;
        int n;
        len = 2'd0;
        run_to_exec(n);
        vecs++; if (n !== 2) begin errs++; $display("FAIL rd_latency got %0d want 2", n); end
        finish_insn(1'b1, 16'h1234);
        vecs++; if (mem_addr !== 16'h1234) begin errs++; $display("FAIL rd_with_done got %h want 1234", mem_addr); end
        len = 2'd2;
        @(negedge clk);
        pc_load   = 1'b1;
        pc_target = 16'h0BAD;
        vecs++; if (mem_addr !== 16'h1235) begin errs++; $display("FAIL rd_op1_addr got %h want 1235", mem_addr); end
        @(negedge clk);
        pc_load = 1'b0;
        vecs++; if (mem_addr !== 16'h1236) begin errs++; $display("FAIL rd_fetch_d_ignored got %h want 1236", mem_addr); end
        @(negedge clk);
        vecs++; if ({exec, insn, d1, d2} !== {1'b1, 8'h40, 8'h77, 8'h88}) begin errs++; $display("FAIL rd_bundle got %b %h %h %h want 1 40 77 88", exec, insn, d1, d2); end
        pc_load   = 1'b1;
        pc_target = 16'h1234;
        @(negedge clk);
        pc_load = 1'b0;
        @(negedge clk);
        vecs++; if ({insn, d1, d2, insn_pc} !== {8'h40, 8'h77, 8'h88, 16'h1234}) begin errs++; $display("FAIL rd_bundle_stable got %h %h %h %h", insn, d1, d2, insn_pc); end
        finish_insn(1'b0, 16'h0000);
        vecs++; if (mem_addr !== 16'h1234) begin errs++; $display("FAIL rd_early_load got %h want 1234", mem_addr); end
        run_to_exec(n);
        vecs++; if (n !== 3) begin errs++; $display("FAIL rd_second_latency got %0d want 3", n); end
        finish_insn(1'b1, 16'hFFFE);
        vecs++; if (mem_addr !== 16'hFFFE) begin errs++; $display("FAIL rd_to_wrap got %h want fffe", mem_addr); end
    endtask

    task automatic test_wrap_and_reset;
        len = 2'd2;
        @(negedge clk);
        vecs++; if (mem_addr !== 16'hFFFF) begin errs++; $display("FAIL wrap_op1_addr got %h want ffff", mem_addr); end
        @(negedge clk);
        vecs++; if (mem_addr !== 16'h0000) begin errs++; $display("FAIL wrap_op2_addr got %h want 0000", mem_addr); end
        @(negedge clk);
        vecs++; if ({exec, insn, d1, d2, insn_pc} !== {1'b1, 8'h55, 8'hA1, 8'h0D, 16'hFFFE}) begin errs++; $display("FAIL wrap_bundle got %b %h %h %h %h", exec, insn, d1, d2, insn_pc); end
        finish_insn(1'b0, 16'h0000);
        vecs++; if (mem_addr !== 16'h0001) begin errs++; $display("FAIL wrap_next_addr got %h want 0001", mem_addr); end
        wait_n = 3;
        repeat (9) @(negedge clk);
        vecs++; if ({mem_req, mem_addr, d1} !== {1'b1, 16'h0003, 8'h32}) begin errs++; $display("FAIL mr_pre got req=%b addr=%h d1=%h want 1/0003/32", mem_req, mem_addr, d1); end
        rst = 1'b0;
        #1;
        vecs++; if ({mem_req, exec, mem_addr} !== {2'b00, 16'h0000}) begin errs++; $display("FAIL mr_ctrl got req=%b exec=%b addr=%h want 0/0/0000", mem_req, exec, mem_addr); end
        vecs++; if ({insn, d1, d2, d3, is, insn_pc} !== 51'h0) begin errs++; $display("FAIL mr_regs got %h %h %h %h %h %h want 0", insn, d1, d2, d3, is, insn_pc); end
        @(negedge clk);
        wait_n = 0;
        rst    = 1'b1;
        #1;
        vecs++; if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin errs++; $display("FAIL mr_release got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
    endtask

    initial begin
        vecs        = 0;
        errs        = 0;
        wcnt        = 0;
        ack_count   = 0;
        wait_n      = 0;
        rand_ack_en = 1'b1;
        rand_ack    = 1'b0;
        rst         = 1'b0;
        len         = 2'd0;
        done        = 1'b0;
        pc_load     = 1'b0;
        pc_target   = 16'h0000;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0000] = 8'h0D; mem[16'h0001] = 8'h64; mem[16'h0002] = 8'h32; mem[16'h0003] = 8'h40;
        mem[16'h0004] = 8'h18;
        mem[16'h0005] = 8'h21; mem[16'h0006] = 8'h5A;
        mem[16'h0007] = 8'h30;
        mem[16'h1234] = 8'h40; mem[16'h1235] = 8'h77; mem[16'h1236] = 8'h88;
        mem[16'hFFFE] = 8'h55; mem[16'hFFFF] = 8'hA1;

        test_reset;
        test_three_operands;
        test_zero_operands;
        test_wait_states;
        test_redirect;
        test_wrap_and_reset;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
